// File: rtl/ps2_key_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_assembler
// Description : Groups PS/2 set-2 scan-code bytes (E0/F0/E1 prefixes plus the
//               final code) into one 65-bit ps2_key event word with a toggle bit.
//               Optional macro PS2_KEY_HOSTRSP_EN drops host-response bytes in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_assembler #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [64:0] ps2_key,
    output logic        key_strobe,
    output logic        busy,
    output logic        seq_err
);

    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREFIX = 2'd1,
        S_HOLD   = 2'd2,
        S_PAUSE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [63:0]     r_sreg;
    logic [3:0]      r_cnt;
    logic [c_TW-1:0] r_tmo;

    logic [63:0] w_sreg_nxt;
    logic        w_is_pfx;
    logic        w_fake;
    logic        w_full;
    logic        w_drop;
    logic        w_emit;
    logic        w_discard;
    logic        w_collect;
    state_t      w_state_nxt;

    assign w_sreg_nxt = {r_sreg[55:0], byte_data};
    assign w_is_pfx   = (byte_data == 8'hE0) || (byte_data == 8'hF0);
    assign w_full     = (r_cnt == 4'd8);
    // Fake shift: a 12 directly after E0 or E0 F0 belongs to a longer sequence.
    assign w_fake     = (byte_data == 8'h12) &&
                        (((r_cnt == 4'd1) && (r_sreg[7:0]  == 8'hE0)) ||
                         ((r_cnt == 4'd2) && (r_sreg[15:0] == 16'hE0F0)));

`ifdef PS2_KEY_HOSTRSP_EN
    assign w_drop = (byte_data == 8'hFA) || (byte_data == 8'hAA) ||
                    (byte_data == 8'hFE) || (byte_data == 8'hEE) ||
                    (byte_data == 8'h00) || (byte_data == 8'hFF);
`else
    assign w_drop = 1'b0;
`endif

    always_comb begin
        w_emit      = 1'b0;
        w_discard   = 1'b0;
        w_collect   = 1'b0;
        w_state_nxt = r_state;
        if (byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_drop) begin
                        if (byte_data == 8'hE1) begin
                            w_collect   = 1'b1;
                            w_state_nxt = S_PAUSE;
                        end else if (w_is_pfx) begin
                            w_collect   = 1'b1;
                            w_state_nxt = S_PREFIX;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (r_cnt == 4'd7) begin
                        w_emit      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_collect = 1'b1;
                    end
                end
                default: begin
                    if (w_full) begin
                        w_discard   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_is_pfx) begin
                        w_collect   = 1'b1;
                        w_state_nxt = S_PREFIX;
                    end else if ((r_state == S_PREFIX) && w_fake) begin
                        w_collect   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_emit      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end else if ((r_state != S_IDLE) && (r_tmo == c_TMO_LAST)) begin
            w_discard   = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sreg     <= 64'd0;
            r_cnt      <= 4'd0;
            r_tmo      <= '0;
            ps2_key    <= 65'd0;
            key_strobe <= 1'b0;
            busy       <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            key_strobe <= w_emit;
            seq_err    <= w_discard;
            r_state    <= w_state_nxt;
            busy       <= (w_state_nxt != S_IDLE);
            if (w_emit) begin
                ps2_key <= {~ps2_key[64], w_sreg_nxt};
                r_sreg  <= 64'd0;
                r_cnt   <= 4'd0;
            end else if (w_discard) begin
                r_sreg  <= 64'd0;
                r_cnt   <= 4'd0;
            end else if (w_collect) begin
                r_sreg  <= w_sreg_nxt;
                r_cnt   <= r_cnt + 4'd1;
            end
            // Idle counter only runs while a sequence is open and no byte arrives.
            if (byte_valid || (w_state_nxt == S_IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_assembler
// Description : Table, directed and random checks of ps2_key_assembler against
//               a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_assembler;

    localparam int c_TMO = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [64:0] ps2_key;
    logic        key_strobe;
    logic        busy;
    logic        seq_err;

    int checks = 0;
    int errors = 0;

    ps2_key_assembler #(.TIMEOUT_CYC(c_TMO)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .busy       (busy),
        .seq_err    (seq_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: pending bytes of the open sequence, idle-cycle count.
    logic [7:0]  mq[$];
    int          midle;
    logic [64:0] mkey;
    logic        mstb;
    logic        merr;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [64:0] key;
        logic        stb;
        logic        bsy;
    } vec_t;
    vec_t tbl[$];

    function automatic bit is_rsp(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_emit();
        logic [63:0] w;
        w = 64'd0;
        foreach (mq[i]) w = {w[55:0], mq[i]};
        mkey = {~mkey[64], w};
        mstb = 1'b1;
        mq.delete();
    endtask

    task automatic m_byte(input logic [7:0] b);
        bit pfx;
        pfx = (b == 8'hE0) || (b == 8'hF0);
        if (mq.size() == 0) begin
`ifdef PS2_KEY_HOSTRSP_EN
            if (is_rsp(b)) return;
`endif
            if (pfx || b == 8'hE1) mq.push_back(b);
            else begin mq.push_back(b); m_emit(); end
        end else if (mq[0] == 8'hE1) begin
            mq.push_back(b);
            if (mq.size() == 8) m_emit();
        end else if (mq.size() == 8) begin
            mq.delete();
            merr = 1'b1;
        end else if (pfx) begin
            mq.push_back(b);
        end else if (b == 8'h12 && ((mq.size() == 1 && mq[0] == 8'hE0) ||
                     (mq.size() == 2 && mq[0] == 8'hE0 && mq[1] == 8'hF0))) begin
            mq.push_back(b);
        end else begin
            mq.push_back(b);
            m_emit();
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".key"}, ps2_key, mkey);
        chk({tag, ".strobe"}, {64'd0, key_strobe}, {64'd0, mstb});
        chk({tag, ".busy"}, {64'd0, busy}, {64'd0, (mq.size() != 0)});
        chk({tag, ".seq_err"}, {64'd0, seq_err}, {64'd0, merr});
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input string tag);
        @(negedge clk_sys);
        byte_valid = v;
        byte_data  = d;
        @(posedge clk_sys);
        #1;
        mstb = 1'b0;
        merr = 1'b0;
        if (v) begin
            midle = 0;
            m_byte(d);
        end else if (mq.size() != 0) begin
            midle++;
            if (midle == c_TMO) begin
                mq.delete();
                merr  = 1'b1;
                midle = 0;
            end
        end
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_sys);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk_sys);
        #1;
        mq.delete();
        midle = 0;
        mkey  = 65'd0;
        mstb  = 1'b0;
        merr  = 1'b0;
        check_model(tag);
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [64:0] k,
                       input logic s, input logic b);
        vec_t e;
        e.v = v; e.d = d; e.key = k; e.stb = s; e.bsy = b;
        tbl.push_back(e);
    endtask

    initial begin
        logic [64:0] k1, k2, k3, k4;
        logic [7:0]  pb;
        int          r;
        int          gap;

        k1 = {1'b1, 64'h1C};
        k2 = {1'b0, 64'hE0F075};
        k3 = {1'b1, 64'hE11477E1F014F077};
        k4 = {1'b0, 64'hE012E07C};
        add(1, 8'h1C, k1, 1, 0);
        add(0, 8'h00, k1, 0, 0);
        add(1, 8'hE0, k1, 0, 1);
        add(1, 8'hF0, k1, 0, 1);
        add(1, 8'h75, k2, 1, 0);
        add(1, 8'hE1, k2, 0, 1);
        add(1, 8'h14, k2, 0, 1);
        add(1, 8'h77, k2, 0, 1);
        add(1, 8'hE1, k2, 0, 1);
        add(1, 8'hF0, k2, 0, 1);
        add(1, 8'h14, k2, 0, 1);
        add(1, 8'hF0, k2, 0, 1);
        add(1, 8'h77, k3, 1, 0);
        add(1, 8'hE0, k3, 0, 1);
        add(1, 8'h12, k3, 0, 1);
        add(0, 8'h00, k3, 0, 1);
        add(1, 8'hE0, k3, 0, 1);
        add(1, 8'h7C, k4, 1, 0);

        do_reset("reset");
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].d, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.key", i), ps2_key, tbl[i].key);
            chk($sformatf("tbl%0d.strobe", i), {64'd0, key_strobe}, {64'd0, tbl[i].stb});
            chk($sformatf("tbl%0d.busy", i), {64'd0, busy}, {64'd0, tbl[i].bsy});
        end

        // Timeout: E0 then TIMEOUT idle cycles.
        cycle(1, 8'hE0, "tmo.e0");
        for (int k = 1; k <= c_TMO; k++) begin
            cycle(0, 8'h00, "tmo.idle");
            chk("tmo.err", {64'd0, seq_err}, {64'd0, (k == c_TMO)});
            chk("tmo.busy", {64'd0, busy}, {64'd0, (k < c_TMO)});
        end
        chk("tmo.key_kept", ps2_key, k4);
        cycle(1, 8'h29, "tmo.29");
        chk("tmo.after", ps2_key, {1'b1, 64'h29});

        // Byte arriving in the expiry cycle is accepted.
        cycle(1, 8'hE0, "exp.e0");
        for (int k = 1; k < c_TMO; k++) cycle(0, 8'h00, "exp.idle");
        cycle(1, 8'h7C, "exp.7c");
        chk("exp.key", ps2_key, {1'b0, 64'hE07C});
        chk("exp.err", {64'd0, seq_err}, 65'd0);

        // Exactly 8 bytes is legal.
        for (int k = 0; k < 7; k++) cycle(1, 8'hE0, "full.e0");
        cycle(1, 8'h12, "full.12");
        chk("full.key", ps2_key, {1'b1, 64'hE0E0E0E0E0E0E012});

        // Overflow on the ninth byte.
        for (int k = 1; k <= 9; k++) begin
            cycle(1, 8'hE0, "ovf.e0");
            chk("ovf.err", {64'd0, seq_err}, {64'd0, (k == 9)});
            chk("ovf.strobe", {64'd0, key_strobe}, 65'd0);
        end
        cycle(1, 8'h1C, "ovf.1c");
        chk("ovf.after", ps2_key, {1'b0, 64'h1C});

        // Host response byte in IDLE.
        cycle(1, 8'hFA, "rsp.fa");
`ifdef PS2_KEY_HOSTRSP_EN
        chk("rsp.strobe", {64'd0, key_strobe}, 65'd0);
        chk("rsp.key", ps2_key, {1'b0, 64'h1C});
`else
        chk("rsp.strobe", {64'd0, key_strobe}, 65'd1);
        chk("rsp.key", ps2_key, {1'b1, 64'hFA});
`endif

        // Reset mid-sequence.
        cycle(1, 8'hE0, "mid.e0");
        cycle(1, 8'hF0, "mid.f0");
        do_reset("mid.reset");
        chk("mid.key", ps2_key, 65'd0);
        chk("mid.busy", {64'd0, busy}, 65'd0);
        chk("mid.err", {64'd0, seq_err}, 65'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset("rnd.reset");
            end else if (r < 6) begin
                gap = $urandom_range(c_TMO - 3, c_TMO + 3);
                for (int g = 0; g < gap; g++) cycle(0, 8'h00, "rnd.gap");
            end else begin
                case ($urandom_range(0, 9))
                    0, 1:    pb = 8'hE0;
                    2:       pb = 8'hF0;
                    3:       pb = 8'hE1;
                    4:       pb = 8'h12;
                    5:       pb = 8'h7C;
                    6:       pb = 8'hFA;
                    7:       pb = 8'hAA;
                    default: pb = 8'($urandom_range(0, 255));
                endcase
                cycle(($urandom_range(0, 2) != 0), pb, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
